decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage for the rv32i pipelined core. Sits between the fetch output and the execute stage.
- Classifies each instruction into a one-hot type vector and extracts register fields.
- Enforces load-use interlocking through a single-entry load scoreboard with a configurable bubble count.
- Uses valid/ready handshakes on both sides and supports synchronous flush for branch/jump redirects.

Parameters:
- PC_W, 32: width of the program-counter field carried alongside the instruction.
- LOAD_BUBBLES, 1: minimum empty output cycles between a load leaving this stage and a dependent instruction appearing. Legal range is 1..7.
- EN_SYSTEM, 1: 1 decodes FENCE (0001111) and SYSTEM (1110011); 0 flags them illegal.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the output slot and scoreboard.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded instruction is held in the output slot.
- out_ready  in  1  execute consumes the output slot.
- out_type  out  11  one-hot, bit order [0] R, [1] I, [2] STORE, [3] LOAD, [4] BRANCH, [5] JALR, [6] JAL, [7] AUIPC, [8] LUI, [9] FENCE, [10] SYSTEM.
- out_illegal  out  1  opcode unrecognised, instr[1:0] != 2'b11, or FENCE/SYSTEM with EN_SYSTEM=0.
- out_rd, out_rs1, out_rs2  out  5 each  register fields.
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_pc  out  PC_W  registered in_pc.
- out_instr  out  32  registered in_instr.

Behaviour:
- Reset (async, rst=1): out_valid=0; all out_* = 0; scoreboard state=IDLE, ld_rd=0, ld_cnt=0. Reset mid-stall discards the pending instruction and the scoreboard.
- Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
- Latency: 1 cycle. The slot loads on transfer in, and out_valid=1 the next cycle.
- The slot holds all out_* stable while out_valid && !out_ready.
- On transfer out with no transfer in, out_valid clears.
- Decode:
  - Exactly one out_type bit is set for a legal instruction; out_type=0 when out_illegal=1.
  - Field outputs are always raw bit slices, regardless of type.
- Register usage (hazard check only):
  - rs1 is used by R, I, LOAD, STORE, BRANCH, JALR, and by SYSTEM when funct3[2]=0 and funct3!=0.
  - rs2 is used by R, STORE, BRANCH.
- hazard = in_valid && state!=IDLE && ld_rd!=0 && ((uses_rs1 && rs1==ld_rd) || (uses_rs2 && rs2==ld_rd)).
- in_ready = (!out_valid || out_ready) && !flush && !hazard && !(in is LOAD && state!=IDLE).
  - A second load always waits for the scoreboard to reach IDLE. This is a decided simplification.
  - in_ready depends combinationally on in_instr.
- Scoreboard FSM:
  - IDLE: a load accepted into the slot -> HELD, ld_rd=rd.
  - HELD (load sits in slot):
    - On its transfer out: if LOAD_BUBBLES=1 -> IDLE; else -> COUNT with ld_cnt=LOAD_BUBBLES-1.
  - COUNT: ld_cnt decrements each cycle; at ld_cnt==1 -> IDLE.
  - Result: a dependent instruction is accepted LOAD_BUBBLES cycles after the load's transfer out, and appears one cycle after that.
- Flush:
  - Takes priority over all other events: out_valid <= 0, state <= IDLE, ld_cnt <= 0.
  - in_ready=0 in the flush cycle; an instruction presented in that cycle is dropped (not accepted).
- A load with rd=x0 still walks the FSM but never raises hazard.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams: OP_R 0110011, OP_I 0010011, OP_STORE 0100011, OP_LOAD 0000011, OP_BRANCH 1100011, OP_JALR 1100111, OP_JAL 1101111, OP_AUIPC 0010111, OP_LUI 0110111, OP_FENCE 0001111, OP_SYSTEM 1110011;
  - the out_type bit-index constants and the TYPE_W=11 constant.
- One combinational sub-module, opcode_classifier: instr in -> one-hot type, illegal, uses_rs1, uses_rs2 out. It is instantiated once on the input side.

Test Plan:
- Reset mid-stall: assert rst while state=COUNT -> out_valid=0, out_type=0, in_ready=1 on the next cycle with no load pending.
- Type sweep, out_ready=1:
  - feed one instruction of each of the 11 opcodes back-to-back -> each out_type one-hot matches, one per cycle, 1-cycle latency;
  - 0x0000007F -> out_illegal=1, out_type=0.
- Load-use, LOAD_BUBBLES=1: lw x5,0(x1) then add x6,x5,x2 -> add held one cycle, out_valid pattern 1,0,1. With LOAD_BUBBLES=3 the pattern is 1,0,0,0,1.
- Non-dependent and x0 cases:
  - lw x5 then add x6,x7,x8 -> no bubble;
  - lw x0 then add x6,x0,x0 -> no bubble;
  - lw x5 then lw x6 -> second load delayed until the scoreboard is IDLE.
- Backpressure: out_ready=0 for 4 cycles with a load in the slot -> outputs stable, in_ready=0. Releasing out_ready starts the bubble count.
- Flush and EN_SYSTEM:
  - flush during HELD with a dependent instruction waiting -> slot cleared, scoreboard IDLE, dependent accepted next cycle;
  - EN_SYSTEM=0 with ecall 0x00000073 -> out_illegal=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared rv32i decode definitions: major opcodes, out_type bit positions and
// the load scoreboard state encoding.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int TYPE_W   = 11;
    localparam int T_R      = 0;
    localparam int T_I      = 1;
    localparam int T_STORE  = 2;
    localparam int T_LOAD   = 3;
    localparam int T_BRANCH = 4;
    localparam int T_JALR   = 5;
    localparam int T_JAL    = 6;
    localparam int T_AUIPC  = 7;
    localparam int T_LUI    = 8;
    localparam int T_FENCE  = 9;
    localparam int T_SYSTEM = 10;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_HELD  = 2'd1,
        SB_COUNT = 2'd2
    } sb_state_e;

    function automatic logic [TYPE_W-1:0] type_onehot(input int unsigned idx);
        type_onehot = {{(TYPE_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/decode_stage_classifier.sv
// Combinational opcode classifier: one-hot instruction type, illegal flag and
// which source registers the instruction reads (for hazard detection only).
module opcode_classifier
    import rv_pkg::*;
#(
    parameter bit EN_SYSTEM = 1'b1
) (
    input  logic [31:0]       instr,
    output logic [TYPE_W-1:0] itype,
    output logic              illegal,
    output logic              uses_rs1,
    output logic              uses_rs2
);

    logic [TYPE_W-1:0] type_s;
    logic              rs1_s;
    logic              rs2_s;
    logic [2:0]        funct3_s;
    logic              unused_s;

    assign funct3_s = instr[14:12];
    assign unused_s = ^{instr[31:15], instr[11:7]};

    // Opcode lookup; anything outside the table (including instr[1:0] != 2'b11) leaves type_s empty.
    always_comb begin
        type_s = '0;
        rs1_s  = 1'b0;
        rs2_s  = 1'b0;
        case (instr[6:0])
            OP_R:      begin type_s = type_onehot(T_R);      rs1_s = 1'b1; rs2_s = 1'b1; end
            OP_I:      begin type_s = type_onehot(T_I);      rs1_s = 1'b1; end
            OP_STORE:  begin type_s = type_onehot(T_STORE);  rs1_s = 1'b1; rs2_s = 1'b1; end
            OP_LOAD:   begin type_s = type_onehot(T_LOAD);   rs1_s = 1'b1; end
            OP_BRANCH: begin type_s = type_onehot(T_BRANCH); rs1_s = 1'b1; rs2_s = 1'b1; end
            OP_JALR:   begin type_s = type_onehot(T_JALR);   rs1_s = 1'b1; end
            OP_JAL:    type_s = type_onehot(T_JAL);
            OP_AUIPC:  type_s = type_onehot(T_AUIPC);
            OP_LUI:    type_s = type_onehot(T_LUI);
            OP_FENCE: begin
                if (EN_SYSTEM) begin
                    type_s = type_onehot(T_FENCE);
                end else begin
                    type_s = '0;
                end
            end
            OP_SYSTEM: begin
                if (EN_SYSTEM) begin
                    type_s = type_onehot(T_SYSTEM);
                    // Only the register-sourced CSR ops read rs1.
                    rs1_s  = !funct3_s[2] && (funct3_s != 3'd0);
                end else begin
                    type_s = '0;
                end
            end
            default: type_s = '0;
        endcase
    end

    assign itype    = type_s;
    assign illegal  = (type_s == '0);
    assign uses_rs1 = rs1_s;
    assign uses_rs2 = rs2_s;

endmodule

// File: rtl/decode_stage.sv
// Registered rv32i decode stage with valid/ready handshakes, flush and a
// single-entry load-use scoreboard enforcing LOAD_BUBBLES empty output cycles.
module decode_stage
    import rv_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int LOAD_BUBBLES = 1,
    parameter bit EN_SYSTEM    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] out_type,
    output logic              out_illegal,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic              out_funct7b5,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       out_instr
);

    logic [TYPE_W-1:0] in_type_s;
    logic              in_illegal_s;
    logic              uses_rs1_s;
    logic              uses_rs2_s;
    logic              is_load_s;
    logic              hazard_s;
    logic              take_in_s;
    logic              take_out_s;
    sb_state_e         state_r;
    logic [4:0]        ld_rd_r;
    logic [2:0]        ld_cnt_r;

    opcode_classifier #(
        .EN_SYSTEM (EN_SYSTEM)
    ) u_classifier (
        .instr    (in_instr),
        .itype    (in_type_s),
        .illegal  (in_illegal_s),
        .uses_rs1 (uses_rs1_s),
        .uses_rs2 (uses_rs2_s)
    );

    assign is_load_s  = in_type_s[T_LOAD];
    assign hazard_s   = in_valid && (state_r != SB_IDLE) && (ld_rd_r != 5'd0) &&
                        ((uses_rs1_s && (in_instr[19:15] == ld_rd_r)) ||
                         (uses_rs2_s && (in_instr[24:20] == ld_rd_r)));
    // A second load waits for IDLE so the scoreboard never has to track two entries.
    assign in_ready   = (!out_valid || out_ready) && !flush && !hazard_s &&
                        !(is_load_s && (state_r != SB_IDLE));
    assign take_in_s  = in_valid && in_ready;
    assign take_out_s = out_valid && out_ready;

    // Output slot: loads on transfer in, holds under backpressure, empties on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_type     <= '0;
            out_illegal  <= 1'b0;
            out_rd       <= 5'd0;
            out_rs1      <= 5'd0;
            out_rs2      <= 5'd0;
            out_funct3   <= 3'd0;
            out_funct7b5 <= 1'b0;
            out_pc       <= '0;
            out_instr    <= 32'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take_in_s) begin
            out_valid    <= 1'b1;
            out_type     <= in_type_s;
            out_illegal  <= in_illegal_s;
            out_rd       <= in_instr[11:7];
            out_rs1      <= in_instr[19:15];
            out_rs2      <= in_instr[24:20];
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_pc       <= in_pc;
            out_instr    <= in_instr;
        end else if (take_out_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Load scoreboard: HELD while the load sits in the slot, then COUNT out the bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= SB_IDLE;
            ld_rd_r  <= 5'd0;
            ld_cnt_r <= 3'd0;
        end else if (flush) begin
            state_r  <= SB_IDLE;
            ld_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                SB_IDLE: begin
                    if (take_in_s && is_load_s) begin
                        state_r <= SB_HELD;
                        ld_rd_r <= in_instr[11:7];
                    end
                end
                SB_HELD: begin
                    if (take_out_s) begin
                        state_r  <= (LOAD_BUBBLES == 1) ? SB_IDLE : SB_COUNT;
                        ld_cnt_r <= 3'(LOAD_BUBBLES - 1);
                    end
                end
                SB_COUNT: begin
                    if (ld_cnt_r == 3'd1) begin
                        state_r  <= SB_IDLE;
                        ld_cnt_r <= 3'd0;
                    end else begin
                        ld_cnt_r <= ld_cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r  <= SB_IDLE;
                    ld_cnt_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three configurations share one stimulus stream and are
// checked each cycle against a timing model plus directed literal expectations.
module tb_decode_stage;

    localparam int LB [3] = '{1, 3, 1};
    localparam bit EN [3] = '{1'b1, 1'b1, 1'b0};

    localparam logic [31:0] LW5     = 32'h0000A283; // lw  x5,0(x1)
    localparam logic [31:0] LW6     = 32'h0000A303; // lw  x6,0(x1)
    localparam logic [31:0] LW0     = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] ADD_DEP = 32'h00228333; // add x6,x5,x2
    localparam logic [31:0] ADD_IND = 32'h00838333; // add x6,x7,x8
    localparam logic [31:0] ADD_X0  = 32'h00000333; // add x6,x0,x0

    logic [31:0] sw_i [12] = '{32'h00228333, 32'h00100093, 32'h0020A023, 32'h0000A283,
                               32'h00000063, 32'h00008067, 32'h0000006F, 32'h00000017,
                               32'h000010B7, 32'h0000000F, 32'h00000073, 32'h0000007F};
    logic [10:0] sw_t [11] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020,
                               11'h040, 11'h080, 11'h100, 11'h200, 11'h400};

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [31:0] pc_ctr = 32'h0000_1000;

    logic        ir  [3];
    logic        ov  [3];
    logic [10:0] ot  [3];
    logic        il  [3];
    logic [4:0]  ord [3];
    logic [4:0]  ors1[3];
    logic [4:0]  ors2[3];
    logic [2:0]  of3 [3];
    logic        of7 [3];
    logic [31:0] opc [3];
    logic [31:0] oin [3];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_stage #(
            .PC_W         (32),
            .LOAD_BUBBLES (LB[g]),
            .EN_SYSTEM    (EN[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .in_valid     (in_valid),
            .in_ready     (ir[g]),
            .in_instr     (in_instr),
            .in_pc        (in_pc),
            .out_valid    (ov[g]),
            .out_ready    (out_ready),
            .out_type     (ot[g]),
            .out_illegal  (il[g]),
            .out_rd       (ord[g]),
            .out_rs1      (ors1[g]),
            .out_rs2      (ors2[g]),
            .out_funct3   (of3[g]),
            .out_funct7b5 (of7[g]),
            .out_pc       (opc[g]),
            .out_instr    (oin[g])
        );
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    // ---- model: decode table and load-use timing from the stage's rules ----
    function automatic logic [10:0] mtype(input logic [31:0] ins, input bit en);
        case (ins[6:0])
            7'h33:   return 11'h001;
            7'h13:   return 11'h002;
            7'h23:   return 11'h004;
            7'h03:   return 11'h008;
            7'h63:   return 11'h010;
            7'h67:   return 11'h020;
            7'h6F:   return 11'h040;
            7'h17:   return 11'h080;
            7'h37:   return 11'h100;
            7'h0F:   return en ? 11'h200 : 11'h000;
            7'h73:   return en ? 11'h400 : 11'h000;
            default: return 11'h000;
        endcase
    endfunction

    function automatic bit muse1(input logic [31:0] ins, input bit en);
        logic [10:0] t;
        t = mtype(ins, en);
        if (t == 11'h400) return ins[14:12] inside {3'd1, 3'd2, 3'd3};
        return (t & 11'h03F) != 11'h000;
    endfunction

    function automatic bit muse2(input logic [31:0] ins, input bit en);
        return (mtype(ins, en) & 11'h015) != 11'h000;
    endfunction

    bit          m_valid [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_instr [3];
    logic [31:0] m_pc    [3];
    bit          m_held  [3] = '{1'b0, 1'b0, 1'b0};
    logic [4:0]  m_rd    [3] = '{5'd0, 5'd0, 5'd0};
    int          m_tout  [3] = '{-100, -100, -100};
    int          cyc = 0;

    function automatic bit mrdy(input int k);
        bit busy, dep;
        busy = m_held[k] || ((cyc - m_tout[k]) < LB[k]);
        dep  = in_valid && (m_rd[k] != 5'd0) &&
               ((muse1(in_instr, EN[k]) && in_instr[19:15] == m_rd[k]) ||
                (muse2(in_instr, EN[k]) && in_instr[24:20] == m_rd[k]));
        return (!m_valid[k] || out_ready) && !flush &&
               !(busy && (dep || mtype(in_instr, EN[k]) == 11'h008));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_valid[k] <= 1'b0;
                m_held[k]  <= 1'b0;
                m_tout[k]  <= -100;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 3; k++) begin
                if (flush) begin
                    m_valid[k] <= 1'b0;
                    m_held[k]  <= 1'b0;
                    m_tout[k]  <= -100;
                end else begin
                    if (in_valid && mrdy(k)) begin
                        m_valid[k] <= 1'b1;
                        m_instr[k] <= in_instr;
                        m_pc[k]    <= in_pc;
                    end else if (m_valid[k] && out_ready) begin
                        m_valid[k] <= 1'b0;
                    end
                    if (in_valid && mrdy(k) && mtype(in_instr, EN[k]) == 11'h008) begin
                        m_held[k] <= 1'b1;
                        m_rd[k]   <= in_instr[11:7];
                    end else if (m_held[k] && m_valid[k] && out_ready) begin
                        m_held[k] <= 1'b0;
                        m_tout[k] <= cyc;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("in_ready", k, ir[k], mrdy(k));
            chk("out_valid", k, ov[k], m_valid[k]);
            if (m_valid[k]) begin
                chk("out_type", k, ot[k], mtype(m_instr[k], EN[k]));
                chk("out_illegal", k, il[k], mtype(m_instr[k], EN[k]) == 11'h000);
                chk("out_fields", k, {ord[k], ors1[k], ors2[k], of3[k], of7[k]},
                    {m_instr[k][11:7], m_instr[k][19:15], m_instr[k][24:20],
                     m_instr[k][14:12], m_instr[k][30]});
                chk("out_pc", k, opc[k], m_pc[k]);
                chk("out_instr", k, oin[k], m_instr[k]);
            end
        end
    end

    // ---- directed stimulus ----
    task automatic present(input logic [31:0] ins);
        in_instr = ins;
        in_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // First instruction a, then b held valid; out_valid sampled for 5 cycles from a's appearance.
    task automatic pair(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] e0, input logic [4:0] m0,
                        input logic [4:0] e1, input logic [4:0] m1);
        logic [4:0] r0, r1;
        present(a);
        in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_start_ready"}, 0, ir[0] && ir[1], 1'b1);
        tick();
        present(b);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            r0[i] = ov[0];
            r1[i] = ov[1];
            tick();
        end
        in_valid = 1'b0;
        chk({nm, "_pattern"}, 0, r0 & m0, e0);
        chk({nm, "_pattern"}, 1, r1 & m1, e1);
        idle(8);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 0, ov[0], 1'b0);
        chk("rst_type", 0, ot[0], 11'h000);
        chk("rst_instr", 0, oin[0], 32'd0);
        chk("rst_pc", 0, opc[0], 32'd0);
        chk("rst_ready", 0, ir[0], 1'b1);
        tick();

        // Type sweep, one per cycle, each visible the cycle after acceptance.
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            present(sw_i[i]);
            @(negedge clk);
            chk("sweep_ready", 0, ir[0], 1'b1);
            if (i > 0) begin
                chk("sweep_valid", 0, ov[0], 1'b1);
                chk("sweep_type", 0, ot[0], sw_t[i-1]);
            end
            if (i == 10) chk("fence_disabled_illegal", 2, il[2], 1'b1);
            if (i == 11) begin
                chk("ecall_disabled_illegal", 2, il[2], 1'b1);
                chk("ecall_disabled_type", 2, ot[2], 11'h000);
                chk("ecall_enabled_illegal", 0, il[0], 1'b0);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("illegal_7f", 0, il[0], 1'b1);
        chk("illegal_7f_type", 0, ot[0], 11'h000);
        tick();
        idle(8);

        pair("load_use", LW5, ADD_DEP, 5'b00101, 5'b00111, 5'b10001, 5'b11111);
        pair("no_dep",   LW5, ADD_IND, 5'b00011, 5'b00011, 5'b00011, 5'b00011);
        pair("x0_dest",  LW0, ADD_X0,  5'b00011, 5'b00011, 5'b00011, 5'b00011);
        pair("two_load", LW5, LW6,     5'b00101, 5'b00111, 5'b10001, 5'b11111);

        // Backpressure with the load parked in the slot.
        out_ready = 1'b0;
        present(LW5);
        in_valid = 1'b1;
        tick();
        present(ADD_DEP);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", 0, ov[0], 1'b1);
            chk("bp_instr", 0, oin[0], LW5);
            chk("bp_type", 0, ot[0], 11'h008);
            chk("bp_ready", 0, ir[0], 1'b0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 0, ir[0], 1'b0);
        tick();
        @(negedge clk);
        chk("bp_bubble_valid", 0, ov[0], 1'b0);
        chk("bp_bubble_ready", 0, ir[0], 1'b1);
        tick();
        @(negedge clk);
        chk("bp_dep_valid", 0, ov[0], 1'b1);
        chk("bp_dep_instr", 0, oin[0], ADD_DEP);
        tick();
        idle(8);

        // Flush while HELD with the dependent instruction waiting.
        out_ready = 1'b0;
        present(LW5);
        in_valid = 1'b1;
        tick();
        present(ADD_DEP);
        @(negedge clk);
        chk("flush_pre_ready", 0, ir[0], 1'b0);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_ready", 0, ir[0], 1'b0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_cleared", 0, ov[0], 1'b0);
        chk("flush_dep_ready", 0, ir[0], 1'b1);
        chk("flush_dep_ready", 1, ir[1], 1'b1);
        tick();
        @(negedge clk);
        chk("flush_dep_valid", 0, ov[0], 1'b1);
        chk("flush_dep_instr", 0, oin[0], ADD_DEP);
        tick();
        out_ready = 1'b1;
        idle(8);

        // Asynchronous reset while the LOAD_BUBBLES=3 instance is counting.
        present(LW5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rs_load_valid", 1, ov[1], 1'b1);
        tick();
        present(ADD_DEP);
        in_valid = 1'b1;
        @(negedge clk);
        chk("rs_count_ready", 1, ir[1], 1'b0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rs_valid", 1, ov[1], 1'b0);
        chk("rs_type", 1, ot[1], 11'h000);
        chk("rs_ready", 1, ir[1], 1'b1);
        tick();
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
